// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole controller: state codes, LFSR taps and default seed.
package whack_pkg;

    // State codes are also decoded by drawImage and the LED logic.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_GAP       = 3'd1;
    localparam logic [2:0] ST_UP        = 3'd2;
    localparam logic [2:0] ST_GAME_OVER = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_GAP       = ST_GAP,
        S_UP        = ST_UP,
        S_GAME_OVER = ST_GAME_OVER
    } game_state_e;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/whack_lfsr.sv
// Free-running 16-bit Galois LFSR; loads SEED on reset and advances every clock.
module whack_lfsr
    import whack_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= SEED;
        end else begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole game controller: mole pick, game/mole timers, scoring and high score.
// Build option WHACK_MISS_PENALTY_EN: each miss decrements the score, saturating at 0.
module whack_game_ctrl
    import whack_pkg::*;
#(
    parameter int          NUM_MOLES  = 4,
    parameter int          SCORE_W    = 8,
    parameter int          TIME_W     = 7,
    parameter int          GAME_TICKS = 60,
    parameter int          MOLE_TICKS = 2,
    parameter logic [15:0] LFSR_SEED  = DEFAULT_SEED
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_i,
    input  logic                 start_i,
    input  logic [NUM_MOLES-1:0] hit_i,
    output logic [2:0]           state_o,
    output logic [NUM_MOLES-1:0] mole_o,
    output logic [SCORE_W-1:0]   score_o,
    output logic [SCORE_W-1:0]   high_score_o,
    output logic [TIME_W-1:0]    time_left_o,
    output logic                 hit_o,
    output logic                 miss_o,
    output logic                 draw_req_o
);

    localparam int IDX_W = $clog2(NUM_MOLES);
    localparam int MT_W  = $clog2(MOLE_TICKS + 1);

    game_state_e          state, state_next, state_prev;
    logic [15:0]          lfsr;
    logic                 start_q, start_p, start_edge;
    logic [NUM_MOLES-1:0] hit_q, hit_p, hit_edge;
    logic [NUM_MOLES-1:0] mole;
    logic [SCORE_W-1:0]   score, high_score;
    logic [TIME_W-1:0]    time_left;
    logic [MT_W-1:0]      mole_timer;
    logic [IDX_W-1:0]     prev_idx, raw_idx, pick_idx;
    logic                 prev_valid;
    logic                 game_end, correct, wrong, timeout, hit_ev, miss_ev;

    whack_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (lfsr)
    );

    assign start_edge = start_q & ~start_p;
    assign hit_edge   = hit_q & ~hit_p;

    // Never repeat the previous mole: bump to the next hole on a collision.
    always_comb begin
        raw_idx  = IDX_W'(lfsr % 16'(NUM_MOLES));
        pick_idx = raw_idx;
        if (prev_valid && raw_idx == prev_idx) begin
            pick_idx = (raw_idx == IDX_W'(NUM_MOLES - 1)) ? '0 : raw_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        game_end   = 1'b0;
        correct    = 1'b0;
        wrong      = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_edge) state_next = S_GAP;
            end
            S_GAP: begin
                if (tick_i) begin
                    if (time_left == TIME_W'(1)) begin
                        game_end   = 1'b1;
                        state_next = S_GAME_OVER;
                    end else begin
                        state_next = S_UP;
                    end
                end
            end
            S_UP: begin
                correct = |(hit_edge & mole);
                wrong   = (|hit_edge) & ~correct;
                timeout = tick_i && (mole_timer == MT_W'(MOLE_TICKS - 1));
                // The final game tick overrides whatever else happens this cycle.
                if (tick_i && time_left == TIME_W'(1)) begin
                    game_end   = 1'b1;
                    state_next = S_GAME_OVER;
                end else if (correct || timeout) begin
                    state_next = S_GAP;
                end
            end
            S_GAME_OVER: begin
                if (start_edge) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        hit_ev  = correct & ~game_end;
        miss_ev = (wrong | timeout) & ~correct & ~game_end;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q    <= 1'b0;
            start_p    <= 1'b0;
            hit_q      <= '0;
            hit_p      <= '0;
            mole       <= '0;
            score      <= '0;
            high_score <= '0;
            time_left  <= '0;
            mole_timer <= '0;
            prev_idx   <= '0;
            prev_valid <= 1'b0;
            hit_o      <= 1'b0;
            miss_o     <= 1'b0;
            draw_req_o <= 1'b0;
            state_prev <= S_IDLE;
        end else begin
            start_q    <= start_i;
            start_p    <= start_q;
            hit_q      <= hit_i;
            hit_p      <= hit_q;
            hit_o      <= hit_ev;
            miss_o     <= miss_ev;
            state_prev <= state;
            draw_req_o <= (state != state_prev);
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        score     <= '0;
                        time_left <= TIME_W'(GAME_TICKS);
                    end
                end
                S_GAP: begin
                    if (tick_i) begin
                        time_left <= time_left - TIME_W'(1);
                        if (!game_end) begin
                            mole       <= NUM_MOLES'(1) << pick_idx;
                            prev_idx   <= pick_idx;
                            prev_valid <= 1'b1;
                            mole_timer <= '0;
                        end
                    end
                end
                S_UP: begin
                    if (tick_i) begin
                        time_left  <= time_left - TIME_W'(1);
                        mole_timer <= mole_timer + MT_W'(1);
                    end
                    if (game_end || hit_ev || (miss_ev && timeout)) mole <= '0;
                    if (hit_ev && score != '1) score <= score + SCORE_W'(1);
`ifdef WHACK_MISS_PENALTY_EN
                    if (miss_ev && score != '0) score <= score - SCORE_W'(1);
`endif
                end
                S_GAME_OVER: begin
                    if (score > high_score) high_score <= score;
                end
                default: ;
            endcase
        end
    end

    assign state_o      = state;
    assign mole_o       = mole;
    assign score_o      = score;
    assign high_score_o = high_score;
    assign time_left_o  = time_left;

endmodule
